car_nav_ctrl: RTL

//  Manoeuvre sequencer for the car obstacle-avoidance path. Debounces the

---
 rtl/car_nav_ctrl_if.sv | 10 +
 rtl/car_nav_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/car_nav_ctrl_if.sv
// Remote command handshake for car_nav_ctrl: the sender (master) holds
// cmd_valid/cmd_dir until the sequencer (slave) raises cmd_ready.
interface car_nav_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/car_nav_ctrl.sv
// Obstacle-avoidance manoeuvre sequencer: debounced sensors feed a timed FSM that
// drives the go_* lines. Define REVERSE_EN to build the timed reverse (REV) manoeuvre.
module car_nav_ctrl #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned TURN_CYCLES = 8,
    parameter int unsigned REV_CYCLES  = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 front,
    input  logic                 left,
    input  logic                 right,
    car_nav_ctrl_if.slave        cmd,
    output logic                 go_front,
    output logic                 go_left,
    output logic                 go_right,
    output logic                 go_back,
    output logic [2:0]           state_o
);

    if ((DEB_CYCLES < 1) || (TURN_CYCLES < 1) || (REV_CYCLES < 1) ||
        (DEB_CYCLES >= (2 ** CNT_W)) || (TURN_CYCLES >= (2 ** CNT_W)) ||
        (REV_CYCLES >= (2 ** CNT_W))) begin : g_bad_cfg
        $error("car_nav_ctrl: cycle counts must be >=1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

`ifdef REVERSE_EN
    localparam logic [CNT_W-1:0] REV_LOAD = CNT_W'(REV_CYCLES - 1);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FWD = 3'd1, TURN_L = 3'd2, TURN_R = 3'd3, HALT = 3'd4, REV = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, FWD = 3'd1, TURN_L = 3'd2, TURN_R = 3'd3, HALT = 3'd4
    } state_t;
`endif

    // ---------------- sensor debounce (bit 0 front, 1 left, 2 right)
    logic [2:0]       raw;
    logic [2:0]       filt;
    logic [CNT_W-1:0] deb_cnt [3];

    assign raw = {right, left, front};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (raw[i] != filt[i]) begin
                    // the increment that would reach DEB_CYCLES flips the filter instead
                    if (deb_cnt[i] >= DEB_LAST) begin
                        filt[i]    <= raw[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    logic f_front, f_left, f_right;
    assign f_front = filt[0];
    assign f_left  = filt[1];
    assign f_right = filt[2];

    // ---------------- manoeuvre FSM
    state_t           state, nxt, avoid_st, cmd_st;
    logic             halt_cmd, nxt_halt;
    logic [CNT_W-1:0] timer;
    logic             cmd_rdy, cmd_acc;

    assign cmd_rdy       = enable & ~f_front & ((state == FWD) | (state == HALT));
    assign cmd.cmd_ready = cmd_rdy;
    assign cmd_acc       = cmd.cmd_valid & cmd_rdy;
    assign state_o       = state;

    always_comb begin
        avoid_st = HALT;
        if (!f_right)     avoid_st = TURN_R;
        else if (!f_left) avoid_st = TURN_L;

        case (cmd.cmd_dir)
            2'b01:   cmd_st = TURN_L;
            2'b10:   cmd_st = TURN_R;
            2'b11:   cmd_st = HALT;
            default: cmd_st = FWD;
        endcase

        nxt      = state;
        nxt_halt = halt_cmd;
        if (!enable) begin
            nxt      = IDLE;
            nxt_halt = 1'b0;
        end else begin
            case (state)
                IDLE: nxt = FWD;
                FWD: begin
                    if (f_front) begin
`ifdef REVERSE_EN
                        nxt = (f_right && f_left) ? REV : avoid_st;
`else
                        nxt = avoid_st;
`endif
                    end else if (cmd_acc) begin
                        nxt = cmd_st;
                        if (cmd.cmd_dir == 2'b11) nxt_halt = 1'b1;
                    end
                end
                TURN_L, TURN_R: if (timer == '0) nxt = FWD;
                HALT: begin
                    if (!f_front) begin
                        if (cmd_acc) begin
                            nxt = cmd_st;
                            if (cmd.cmd_dir == 2'b11)      nxt_halt = 1'b1;
                            else if (cmd.cmd_dir == 2'b00) nxt_halt = 1'b0;
                        end else if (!halt_cmd) begin
                            nxt = FWD;
                        end
                    end
                end
`ifdef REVERSE_EN
                REV: if (timer == '0) nxt = avoid_st;
`endif
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            halt_cmd <= 1'b0;
            timer    <= '0;
            go_front <= 1'b0;
            go_left  <= 1'b0;
            go_right <= 1'b0;
        end else begin
            state    <= nxt;
            halt_cmd <= nxt_halt;
            go_front <= (nxt == FWD);
            go_left  <= (nxt == TURN_L);
            go_right <= (nxt == TURN_R);
            // timer reloads on every entry so a turn always runs its full length
            if ((nxt != state) && ((nxt == TURN_L) || (nxt == TURN_R)))
                timer <= TURN_LOAD;
`ifdef REVERSE_EN
            else if ((nxt != state) && (nxt == REV))
                timer <= REV_LOAD;
`endif
            else if (timer != '0)
                timer <= timer - 1'b1;
        end
    end

`ifdef REVERSE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) go_back <= 1'b0;
        else        go_back <= (nxt == REV);
    end
`else
    assign go_back = 1'b0;
`endif

endmodule
